// File: rtl/alu_op_sequencer.sv
// Replays a small loaded program of (fsel, A) ops into the
// accumulator write port over a valid/ready handshake.
module alu_op_sequencer #(
  parameter int PROG_DEPTH = 8,
  parameter int STEP_GAP   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          prog_we,
  input  logic [$clog2(PROG_DEPTH)-1:0] prog_addr,
  input  logic [2:0]                    prog_fsel,
  input  logic [3:0]                    prog_a,
  input  logic                          prog_last,
  input  logic                          start,
  input  logic                          stop,
  input  logic                          loop_en,
  output logic                          op_valid,
  input  logic                          op_ready,
  output logic [2:0]                    op_fsel,
  output logic [3:0]                    op_a,
  output logic                          busy,
  output logic                          done,
  output logic [$clog2(PROG_DEPTH)-1:0] pc
);

  localparam int AW = $clog2(PROG_DEPTH);
  localparam int GW = (STEP_GAP > 1) ? $clog2(STEP_GAP) : 1;

  localparam logic [AW-1:0] PC_MAX  = AW'(PROG_DEPTH - 1);
  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  localparam logic [GW-1:0] GAP_LD  = GW'(STEP_GAP - 1);
  localparam logic [GW-1:0] GAP_ONE = GW'(1);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    GAP,
    DONE
  } state_t;

  state_t        state;
  logic [GW-1:0] gap_cnt;
  logic [7:0]    mem [PROG_DEPTH];

  logic [7:0] cur;
  logic       prog_ok;
  logic       accept;
  logic       at_end;

  // entry layout: {last, fsel[2:0], a[3:0]}
  assign cur     = mem[pc];
  assign prog_ok = (state == IDLE) || (state == DONE);
  assign accept  = (state == ISSUE) && op_valid && op_ready;
  assign at_end  = cur[7] || (pc == PC_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < PROG_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (prog_we && prog_ok) begin
      mem[prog_addr] <= {prog_last, prog_fsel, prog_a};
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      pc       <= '0;
      gap_cnt  <= '0;
      op_valid <= 1'b0;
      op_fsel  <= '0;
      op_a     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else if (stop) begin
      state    <= IDLE;
      pc       <= '0;
      gap_cnt  <= '0;
      op_valid <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= ISSUE;
            pc       <= '0;
            op_valid <= 1'b1;
            op_fsel  <= mem[0][6:4];
            op_a     <= mem[0][3:0];
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        ISSUE: begin
          if (accept) begin
            op_valid <= 1'b0;
            if (at_end && !loop_en) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= GAP;
              gap_cnt <= GAP_LD;
              pc      <= at_end ? '0 : pc + PC_ONE;
            end
          end
        end
        GAP: begin
          // pc already points at the next entry here
          if (gap_cnt == '0) begin
            state    <= ISSUE;
            op_valid <= 1'b1;
            op_fsel  <= cur[6:4];
            op_a     <= cur[3:0];
          end else begin
            gap_cnt <= gap_cnt - GAP_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: directed programs,
// expected ops queued at issue and checked by a monitor.
module tb_alu_op_sequencer;

  localparam int DEPTH = 8;
  localparam int GAPC  = 4;

  logic       clock = 1'b0;
  logic       reset;
  logic       prog_we;
  logic [2:0] prog_addr;
  logic [2:0] prog_fsel;
  logic [3:0] prog_a;
  logic       prog_last;
  logic       start;
  logic       stop;
  logic       loop_en;
  logic       op_valid;
  logic       op_ready;
  logic [2:0] op_fsel;
  logic [3:0] op_a;
  logic       busy;
  logic       done;
  logic [2:0] pc;

  int n_cmp = 0;
  int n_bad = 0;
  int n_acc = 0;
  int low_cnt = 0;
  bit gap_pend = 0;
  logic [6:0] exp_q [$];

  always #5 clock = ~clock;

  alu_op_sequencer #(
    .PROG_DEPTH(DEPTH),
    .STEP_GAP  (GAPC)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .prog_we  (prog_we),
    .prog_addr(prog_addr),
    .prog_fsel(prog_fsel),
    .prog_a   (prog_a),
    .prog_last(prog_last),
    .start    (start),
    .stop     (stop),
    .loop_en  (loop_en),
    .op_valid (op_valid),
    .op_ready (op_ready),
    .op_fsel  (op_fsel),
    .op_a     (op_a),
    .busy     (busy),
    .done     (done),
    .pc       (pc)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // monitor: pops one expected op per handshake and times gaps
  always @(negedge clock) begin
    if (reset) begin
      gap_pend = 0;
    end else begin
      if (gap_pend && op_valid) begin
        chk("gap_len", 32'(low_cnt), 32'(GAPC));
        gap_pend = 0;
      end else if (gap_pend && (done || !busy)) begin
        gap_pend = 0;
      end else if (gap_pend) begin
        low_cnt++;
      end
      if (op_valid && op_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_op: got %0h want none",
                   {op_fsel, op_a});
        end else begin
          chk("op", 32'({op_fsel, op_a}), 32'(exp_q.pop_front()));
        end
        n_acc++;
        gap_pend = 1;
        low_cnt = 0;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic load(input int ad, input logic [2:0] f,
                      input logic [3:0] a, input logic l);
    prog_we   = 1'b1;
    prog_addr = 3'(ad);
    prog_fsel = f;
    prog_a    = a;
    prog_last = l;
    tick(1);
    prog_we   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic expect_op(input logic [2:0] f, input logic [3:0] a);
    exp_q.push_back({f, a});
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (!done && k < budget) begin
      tick(1);
      k++;
    end
    chk("done_wait", 32'(done), 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int k = 0;
    while (!op_valid && k < budget) begin
      tick(1);
      k++;
    end
    chk("valid_wait", 32'(op_valid), 32'd1);
  endtask

  task automatic wait_acc(input int target, input int budget);
    int k = 0;
    while (n_acc < target && k < budget) begin
      tick(1);
      k++;
    end
    chk("acc_wait", 32'(n_acc >= target), 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    prog_we = 1'b0;
    prog_addr = '0;
    prog_fsel = '0;
    prog_a = '0;
    prog_last = 1'b0;
    start = 1'b0;
    stop = 1'b0;
    loop_en = 1'b0;
    op_ready = 1'b0;
    #2;
    chk("rst_valid", 32'(op_valid), 32'd0);
    chk("rst_op", 32'({op_fsel, op_a}), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    tick(2);
    reset = 1'b0;
    tick(1);

    // reset mid-ISSUE wipes state and program
    for (int i = 0; i < DEPTH; i++) begin
      load(i, 3'(7 - i), 4'(15 - i), 1'b0);
    end
    pulse_start();
    tick(2);
    chk("pre_valid", 32'(op_valid), 32'd1);
    chk("pre_op", 32'({op_fsel, op_a}), 32'h7f);
    expect_op(3'd7, 4'hf);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    wait_valid(20);
    chk("pre_pc", 32'(pc), 32'd1);
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("async_valid", 32'(op_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_pc", 32'(pc), 32'd0);
    tick(2);
    reset = 1'b0;

    // partial reload; no last flag so run ends after entry 7
    load(0, 3'b011, 4'h6, 1'b0);
    load(1, 3'b111, 4'ha, 1'b0);
    expect_op(3'b011, 4'h6);
    expect_op(3'b111, 4'ha);
    for (int i = 2; i < DEPTH; i++) expect_op(3'b000, 4'h0);
    op_ready = 1'b1;
    pulse_start();
    wait_done(200);
    chk("wrap_busy", 32'(busy), 32'd0);
    chk("wrap_pc", 32'(pc), 32'd7);

    // basic three-op program
    load(0, 3'b000, 4'h3, 1'b0);
    load(1, 3'b000, 4'h5, 1'b0);
    load(2, 3'b110, 4'hf, 1'b1);
    expect_op(3'b000, 4'h3);
    expect_op(3'b000, 4'h5);
    expect_op(3'b110, 4'hf);
    pulse_start();
    wait_done(100);
    chk("basic_busy", 32'(busy), 32'd0);
    chk("basic_pc", 32'(pc), 32'd2);

    // backpressure on entry 1
    expect_op(3'b000, 4'h3);
    expect_op(3'b000, 4'h5);
    expect_op(3'b110, 4'hf);
    op_ready = 1'b0;
    pulse_start();
    wait_valid(10);
    op_ready = 1'b1;
    tick(1);
    op_ready = 1'b0;
    wait_valid(20);
    for (int i = 0; i < 10; i++) begin
      chk("bp_valid", 32'(op_valid), 32'd1);
      chk("bp_hold", 32'({op_fsel, op_a}), 32'h05);
      tick(1);
    end
    op_ready = 1'b1;
    wait_done(100);

    // two-entry loop, three passes
    load(0, 3'b010, 4'h1, 1'b0);
    load(1, 3'b100, 4'h2, 1'b1);
    for (int i = 0; i < 3; i++) begin
      expect_op(3'b010, 4'h1);
      expect_op(3'b100, 4'h2);
    end
    loop_en = 1'b1;
    pulse_start();
    wait_acc(n_acc + 5, 200);
    loop_en = 1'b0;
    wait_done(100);
    chk("loop_pc", 32'(pc), 32'd1);

    // write and start during GAP are ignored
    load(0, 3'b001, 4'h7, 1'b0);
    load(1, 3'b011, 4'h8, 1'b1);
    expect_op(3'b001, 4'h7);
    expect_op(3'b011, 4'h8);
    pulse_start();
    wait_acc(n_acc + 1, 50);
    chk("gap_busy", 32'(busy), 32'd1);
    load(1, 3'b111, 4'hf, 1'b1);
    pulse_start();
    wait_done(100);
    chk("gap_pc", 32'(pc), 32'd1);

    // start with stop in the same cycle
    start = 1'b1;
    stop = 1'b1;
    tick(1);
    start = 1'b0;
    stop = 1'b0;
    chk("ss_done", 32'(done), 32'd0);
    chk("ss_busy", 32'(busy), 32'd0);
    chk("ss_pc", 32'(pc), 32'd0);
    tick(5);
    chk("ss_valid", 32'(op_valid), 32'd0);

    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
